// File: rtl/sram_sp_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// sram_sp_port_arbiter_if
//
// Bundles the request, response and SRAM-side signals of the single-port SRAM
// arbiter. The arbiter connects through the slave modport. A testbench or an
// integrating tile connects through the master modport, which drives the
// requester inputs and the SRAM read data.
//
// Signal summary:
//   wr_addr/wr_data/wr_valid/wr_ready   write request channel (buffet fill)
//   rd_addr/rd_valid/rd_ready           read request channel (buffet drain)
//   rd_data/rd_data_valid/rd_data_ready read response channel (buffer head)
//   addr_to_mem/data_to_mem             SRAM address and write data
//   wen_to_mem/ren_to_mem               SRAM write and read enables
//   data_from_mem                       SRAM read data, one cycle after ren
// ----------------------------------------------------------------------------
interface sram_sp_port_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;

    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic              rd_ready;

    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;
    logic              rd_data_ready;

    logic [ADDR_W-1:0] addr_to_mem;
    logic [DATA_W-1:0] data_to_mem;
    logic              wen_to_mem;
    logic              ren_to_mem;
    logic [DATA_W-1:0] data_from_mem;

    // Arbiter side: consumes requests and SRAM data, produces grants and
    // SRAM controls.
    modport slave (
        input  wr_addr, wr_data, wr_valid,
        input  rd_addr, rd_valid,
        input  rd_data_ready,
        input  data_from_mem,
        output wr_ready, rd_ready,
        output rd_data, rd_data_valid,
        output addr_to_mem, data_to_mem, wen_to_mem, ren_to_mem
    );

    // Requester/SRAM side: drives requests and the SRAM read data.
    modport master (
        output wr_addr, wr_data, wr_valid,
        output rd_addr, rd_valid,
        output rd_data_ready,
        output data_from_mem,
        input  wr_ready, rd_ready,
        input  rd_data, rd_data_valid,
        input  addr_to_mem, data_to_mem, wen_to_mem, ren_to_mem
    );
endinterface

// File: rtl/sram_sp_port_arbiter.sv
// ----------------------------------------------------------------------------
// sram_sp_port_arbiter
//
// Shares one single-port SRAM between a write requester and a read requester.
// At most one access is granted per cycle. Under contention the grant
// alternates, with WRITE winning the first tie after reset or flush. Read data
// comes back through a 2-entry in-order response FIFO with valid/ready, so a
// stalled consumer never loses SRAM output. Reads are credit-limited so that
// buffered plus in-flight responses never exceed the FIFO depth.
//
// Ports:
//   clk     clock
//   rst_n   asynchronous active-low reset
//   clk_en  clock enable; 0 freezes all state and suppresses grants
//   flush   synchronous clear of all state; suppresses grants this cycle
//   bus     sram_sp_port_arbiter_if.slave (request, response, SRAM signals)
//
// Read latency: a grant in cycle N drives ren in cycle N, the SRAM returns
// data in N+1 (captured into the FIFO at the end of N+1), and rd_data_valid
// rises in N+2.
// ----------------------------------------------------------------------------
module sram_sp_port_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  flush,
    sram_sp_port_arbiter_if.slave bus
);

    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } grant_t;

    grant_t            last_grant;
    logic              alive;
    logic              inflight;
    logic [1:0]        resp_count;
    logic              head_ptr;
    logic              tail_ptr;
    logic [DATA_W-1:0] resp_mem [2];

    logic              active;
    logic              wr_req;
    logic              rd_eligible;
    logic              push;
    logic              pop;
    logic [1:0]        occ;
    logic              grant_wr;
    logic              grant_rd;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_data;

    // Grants are only possible in cycles where state is allowed to move.
    // 'alive' drops asynchronously with rst_n, so every grant-derived output
    // goes to 0 the moment reset is asserted. It returns on the first edge
    // after release, which leaves one quiet cycle after reset.
    assign active = alive && clk_en && !flush;
    assign wr_req = active && bus.wr_valid;

    // A pop frees a buffer slot in the same cycle, so a read may still be
    // granted when the credit count is full but the head is being consumed.
    assign pop  = active && (resp_count != 2'd0) && bus.rd_data_ready;
    assign push = active && inflight;
    assign occ  = resp_count + {1'b0, inflight};

    assign rd_eligible = active && bus.rd_valid &&
                         ((occ < 2'd2) || ((occ == 2'd2) && pop));

    // One grant per cycle. Under contention the requester that did not win
    // last time gets the SRAM. An ineligible read never blocks a write.
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (wr_req && rd_eligible) begin
            if (last_grant == GRANT_READ) begin
                grant_wr = 1'b1;
            end else begin
                grant_rd = 1'b1;
            end
        end else if (wr_req) begin
            grant_wr = 1'b1;
        end else if (rd_eligible) begin
            grant_rd = 1'b1;
        end
    end

    // SRAM address and data are zero whenever nothing is granted, which keeps
    // the memory-side bus quiet during idle, frozen, flushed or reset cycles.
    always_comb begin
        grant_addr = '0;
        grant_data = '0;
        if (grant_wr) begin
            grant_addr = bus.wr_addr;
            grant_data = bus.wr_data;
        end else if (grant_rd) begin
            grant_addr = bus.rd_addr;
        end
    end

    assign bus.wen_to_mem    = grant_wr;
    assign bus.wr_ready      = grant_wr;
    assign bus.ren_to_mem    = grant_rd;
    assign bus.rd_ready      = grant_rd;
    assign bus.addr_to_mem   = grant_addr;
    assign bus.data_to_mem   = grant_data;
    assign bus.rd_data       = resp_mem[head_ptr];
    assign bus.rd_data_valid = (resp_count != 2'd0);

    // Arbiter state: grant history, the single in-flight read flag and the
    // response FIFO. Flush clears everything even while clk_en is low and
    // drops any in-flight read, so late SRAM data is never captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive       <= 1'b0;
            last_grant  <= GRANT_READ;
            inflight    <= 1'b0;
            resp_count  <= 2'd0;
            head_ptr    <= 1'b0;
            tail_ptr    <= 1'b0;
            resp_mem[0] <= '0;
            resp_mem[1] <= '0;
        end else begin
            alive <= 1'b1;
            if (flush) begin
                last_grant  <= GRANT_READ;
                inflight    <= 1'b0;
                resp_count  <= 2'd0;
                head_ptr    <= 1'b0;
                tail_ptr    <= 1'b0;
                resp_mem[0] <= '0;
                resp_mem[1] <= '0;
            end else if (clk_en) begin
                if (push) begin
                    resp_mem[tail_ptr] <= bus.data_from_mem;
                    tail_ptr           <= ~tail_ptr;
                end
                if (pop) begin
                    head_ptr <= ~head_ptr;
                end
                case ({push, pop})
                    2'b10:   resp_count <= resp_count + 2'd1;
                    2'b01:   resp_count <= resp_count - 2'd1;
                    default: resp_count <= resp_count;
                endcase

                inflight <= grant_rd;

                if (grant_wr) begin
                    last_grant <= GRANT_WRITE;
                end else if (grant_rd) begin
                    last_grant <= GRANT_READ;
                end
            end
        end
    end

`ifndef SYNTHESIS
    // The credit check on read grants must make a push into a full FIFO
    // impossible.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && resp_count == 2'd2))
                else $error("response push into full buffer");
        end
    end
`endif

endmodule
